// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  muldiv_pkg
//  Shared encodings for the iterative RV64M multiply/divide unit.
//  Revision: 1.0
// ============================================================================
package muldiv_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core_u.sv
`default_nettype none
// ============================================================================
//  muldiv_core_u
//  Unsigned radix-2 engine: shift-add multiply / restoring divide, one step
//  per cycle on a shared {hi, lo} register pair.
//  Revision: 1.0
// ============================================================================
module muldiv_core_u
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic            i_op_w,
    input  logic [XLEN-1:0] i_a_mag,
    input  logic [XLEN-1:0] i_b_mag,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_last
);

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            div_q, div_d;
    logic [XLEN:0]   w_sum, w_shl, w_diff;

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        w_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        w_shl  = {hi_q, lo_q[XLEN-1]};
        w_diff = w_shl - {1'b0, b_q};
        if (i_load) begin
            hi_d  = '0;
            b_d   = i_b_mag;
            div_d = i_is_div;
            cnt_d = i_op_w ? 7'd32 : 7'd64;
            // Word divides start with the dividend pre-shifted so 32 steps suffice
            lo_d  = (i_is_div && i_op_w) ? {i_a_mag[31:0], {(XLEN-32){1'b0}}} : i_a_mag;
        end else if (i_step) begin
            cnt_d = cnt_q - 7'd1;
            if (div_q) begin
                if (!w_diff[XLEN]) begin
                    hi_d = w_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = w_shl[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_d = w_sum[XLEN:1];
                lo_d = {w_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

    assign o_hi   = hi_q;
    assign o_lo   = lo_q;
    assign o_last = (cnt_q == 7'd1);

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  muldiv_unit
//  Iterative RV64M multiply/divide with START/DONE handshake, flush and
//  single-cycle fast path for divide special cases.
//  Revision: 1.0
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [2:0]      FUNCT3,
    input  logic            OP_W,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      RD_IN,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      RD_OUT
);

    state_t          state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic            opw_q, opw_d, neg_q, neg_d, rem_neg_q, rem_neg_d, fast_q, fast_d;
    logic [XLEN-1:0] fast_res_q, fast_res_d, result_q, result_d;
    logic [4:0]      rd_q, rd_d, rd_out_q, rd_out_d;

    logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_div;
    logic              w_div_zero, w_ovf, w_w_undef, w_accept, w_step, w_last;
    logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_fast_raw;
    logic [XLEN-1:0]   w_hi, w_lo, w_quo, w_rem, w_sel, w_fix_res;
    logic [2*XLEN-1:0] w_prod, w_prod_s;

    always_comb begin : decode
        w_div      = FUNCT3[2];
        w_a_signed = (FUNCT3 != F3_MULHU) && (FUNCT3 != F3_DIVU) && (FUNCT3 != F3_REMU);
        w_b_signed = w_a_signed && (FUNCT3 != F3_MULHSU);
        w_a_ext    = OP_W ? (w_a_signed ? sext_word(A[31:0]) : {32'b0, A[31:0]}) : A;
        w_b_ext    = OP_W ? (w_b_signed ? sext_word(B[31:0]) : {32'b0, B[31:0]}) : B;
        w_a_neg    = w_a_signed && w_a_ext[XLEN-1];
        w_b_neg    = w_b_signed && w_b_ext[XLEN-1];
        w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
        w_min      = OP_W ? sext_word(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        w_w_undef  = OP_W && !w_div && (FUNCT3 != F3_MUL);
        w_div_zero = w_div && (w_b_ext == '0);
        w_ovf      = w_div && !FUNCT3[0] && (w_a_ext == w_min) && (w_b_ext == '1);
        // Undefined word encodings fall through with a zero result
        w_fast_raw = '0;
        if (w_div_zero) begin
            w_fast_raw = FUNCT3[1] ? w_a_ext : '1;
        end else if (w_ovf) begin
            w_fast_raw = FUNCT3[1] ? '0 : w_a_ext;
        end
        if (OP_W) begin
            w_fast_raw = sext_word(w_fast_raw[31:0]);
        end
    end

    assign w_accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && START && !FLUSH;
    assign w_step   = (state_q == ST_CALC) && !FLUSH;

    muldiv_core_u u_core (
        .clk      (CLK),
        .rst      (RESET),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_is_div (w_div),
        .i_op_w   (OP_W),
        .i_a_mag  (w_a_mag),
        .i_b_mag  (w_b_mag),
        .o_hi     (w_hi),
        .o_lo     (w_lo),
        .o_last   (w_last)
    );

    always_comb begin : fix_path
        // A 32-step multiply leaves the product 32 bits high in the register pair
        w_prod   = opw_q ? {32'b0, w_hi, w_lo[XLEN-1:32]} : {w_hi, w_lo};
        w_prod_s = neg_q ? -w_prod : w_prod;
        w_quo    = neg_q ? -w_lo : w_lo;
        w_rem    = rem_neg_q ? -w_hi : w_hi;
        case (f3_q)
            F3_MUL:          w_sel = w_prod_s[XLEN-1:0];
            F3_DIV, F3_DIVU: w_sel = w_quo;
            F3_REM, F3_REMU: w_sel = w_rem;
            default:         w_sel = w_prod_s[2*XLEN-1:XLEN];
        endcase
        if (fast_q) begin
            w_fix_res = fast_res_q;
        end else if (opw_q) begin
            w_fix_res = sext_word(w_sel[31:0]);
        end else begin
            w_fix_res = w_sel;
        end
    end

    always_comb begin : fsm
        state_d    = state_q;
        f3_d       = f3_q;
        opw_d      = opw_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        fast_d     = fast_q;
        fast_res_d = fast_res_q;
        rd_d       = rd_q;
        result_d   = result_q;
        rd_out_d   = rd_out_q;
        case (state_q)
            ST_CALC: if (w_last) state_d = ST_FIX;
            ST_FIX: begin
                state_d  = ST_DONE;
                result_d = w_fix_res;
                rd_out_d = rd_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_accept) begin
            f3_d       = FUNCT3;
            opw_d      = OP_W;
            rd_d       = RD_IN;
            neg_d      = w_a_neg ^ w_b_neg;
            rem_neg_d  = w_a_neg;
            fast_d     = w_div_zero || w_ovf || w_w_undef;
            fast_res_d = w_fast_raw;
            state_d    = fast_d ? ST_FIX : ST_CALC;
        end
        if (FLUSH) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            f3_q       <= '0;
            opw_q      <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            fast_q     <= 1'b0;
            fast_res_q <= '0;
            rd_q       <= '0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            f3_q       <= f3_d;
            opw_q      <= opw_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            fast_q     <= fast_d;
            fast_res_q <= fast_res_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
        end
    end

    assign BUSY   = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign DONE   = (state_q == ST_DONE);
    assign RESULT = result_q;
    assign RD_OUT = rd_out_q;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV64M multiply/divide unit in the execute stage. It consumes the two register-file read operands and produces a 64-bit result plus destination index for the register-file write port. It is multi-cycle with a start/done handshake; the pipeline stalls on BUSY.

Parameters:
XLEN, 64, operand/result width; only 64 is supported, and W-variants are derived internally.

Ports:
CLK  input  1  single clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
START  input  1  request strobe; accepted only when BUSY=0.
FLUSH  input  1  synchronous abort of the in-flight operation.
FUNCT3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
OP_W  input  1  1 = 32-bit word variant (MULW/DIVW/DIVUW/REMW/REMUW).
A  input  64  rs1 value (from R1_DATA).
B  input  64  rs2 value (from R2_DATA).
RD_IN  input  5  destination register index.
BUSY  output  1  high while an operation is in CALC or FIX.
DONE  output  1  one-cycle pulse; RESULT and RD_OUT are valid.
RESULT  output  64  result, held until the next accepted START.
RD_OUT  output  5  destination index captured at START.

Behaviour:
- Reset (async): state IDLE, BUSY=0, DONE=0, RESULT=0, RD_OUT=0, and all internal registers cleared. Reset mid-operation discards the operation and produces no DONE.
- States: IDLE, CALC, FIX, DONE.
- START is accepted at a rising edge when the state is IDLE or DONE. START while BUSY=1 is ignored and has no side effect.
- On accept at edge k:
  - Latch FUNCT3, OP_W and RD_IN.
  - Convert operands to unsigned magnitudes according to signedness. MULHSU: A signed, B unsigned. W-ops use A[31:0]/B[31:0], sign- or zero-extended per op.
  - Record the result sign.
  - State goes to CALC with iteration count N = 64 (OP_W=0) or 32 (OP_W=1).
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 128-bit product.
  - Divide: restoring shift-subtract giving quotient and remainder.
  - Counter decrements each cycle; after N steps, state goes to FIX.
- FIX (1 cycle): apply sign correction, then select the result:
  - MUL/MULW: low 64 bits.
  - MULH*: high 64 bits.
  - DIV*: quotient.
  - REM*: remainder.
  - W-ops: sign-extend bit 31 of the 32-bit result.
  - Write RESULT; state goes to DONE.
- DONE: DONE=1 and BUSY=0 for exactly one cycle. A new START may be accepted in this same cycle; otherwise state goes to IDLE.
- Latency: DONE is sampled high at edge k+N+2 (66 cycles for 64-bit ops, 34 for W-ops).
- Divide special cases skip CALC (edge k goes directly to FIX); DONE is sampled at edge k+2.
  - Divisor zero: quotient = all ones (W: 0xFFFFFFFF sign-extended); remainder = dividend (W: sign-extended low word).
  - Signed overflow (most-negative / -1, per width): quotient = dividend, remainder = 0.
- Undefined W encodings (OP_W=1 with FUNCT3 001/010/011): take the fast path with RESULT=0 and DONE at k+2.
- Signed remainder takes the sign of the dividend; quotient sign = sign(A) XOR sign(B).
- FLUSH=1 at an edge: state goes to IDLE, BUSY=0, no DONE; RESULT and RD_OUT are unchanged. FLUSH has priority over START in the same cycle.
- RD_OUT=0 is legal; write suppression for x0 is the register file's responsibility.

Decomposition:
- Package muldiv_pkg holds:
  - FUNCT3 encoding localparams (F3_MUL … F3_REMU).
  - State encoding (ST_IDLE, ST_CALC, ST_FIX, ST_DONE).
  - XLEN.
- One sub-module, muldiv_core_u: the unsigned iterative engine (product/remainder registers, step counter, add/subtract step). Sign handling, special cases and the FSM remain in muldiv_unit.

Test Plan:
- MUL: A=7, B=-3 (0xFFFF_FFFF_FFFF_FFFD) -> DONE at edge k+66, RESULT=0xFFFF_FFFF_FFFF_FFEB, BUSY high edges k+1..k+65, RD_OUT=RD_IN.
- MULH/MULHU/MULHSU: A=B=0xFFFF_FFFF_FFFF_FFFF -> results 0x0, 0xFFFF_FFFF_FFFF_FFFE, 0xFFFF_FFFF_FFFF_FFFF respectively.
- DIV/REM: A=-20, B=3 -> quotient -6, remainder -2. DIVW: A=0x1_8000_0000, B=-1 -> overflow fast path, RESULT=0xFFFF_FFFF_8000_0000, DONE at k+2.
- Divide by zero: DIVU A=5, B=0 -> 0xFFFF_FFFF_FFFF_FFFF. REMU -> 5. Both DONE at k+2.
- Handshake: START held high during BUSY is ignored; back-to-back START accepted in the DONE cycle; FLUSH at k+10 -> BUSY=0 at k+11 and no DONE.
- Async RESET asserted mid-CALC (between edges) -> BUSY/DONE/RESULT immediately 0; the next START behaves normally.
